serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock, with a single borrow flip-flop.
- Subtraction counterpart to the team's adder primitives. Trades latency for area in datapaths that need an occasional subtract.
- Operand intake and result delivery both use valid/ready handshakes, so it drops between a producer and a consumer without glue.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start_valid  input  1  operands a/b valid.
- start_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend, sampled when start_valid && start_ready.
- b  input  WIDTH  subtrahend, sampled with a.
- diff  output  WIDTH  result a - b, modulo 2^WIDTH.
- borrow  output  1  final borrow out; 1 iff a < b unsigned.
- done_valid  output  1  diff/borrow valid.
- done_ready  input  1  consumer accepts result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n).
- Reset state: on a rising clk with rst_n=0:
  - state=IDLE; diff=0, borrow=0, done_valid=0, busy=0.
  - internal operand shift registers, bit counter and borrow FF cleared.
  - start_ready=1 in the first cycle after rst_n returns high.
- FSM states: IDLE, RUN, DONE. Encoding is free; one-hot or binary.
- IDLE:
  - start_ready=1.
  - On start_valid=1: latch a/b into shift registers, count=0, borrow FF=0, clear diff to 0, go to RUN.
  - diff/borrow hold their previous result until that accept edge.
- RUN, per cycle, with ai=a_sh[0], bi=b_sh[0], br=borrow FF:
  - d = ai ^ bi ^ br.
  - br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - diff shifts right with d inserted at MSB; a_sh and b_sh shift right; count++.
  - When count==WIDTH-1: borrow output <= br_next, go to DONE.
- Latency:
  - RUN lasts exactly WIDTH cycles.
  - done_valid is first high in the cycle following the WIDTH-th edge after the accepting edge (8 edges for WIDTH=8).
- DONE:
  - done_valid=1; diff/borrow stable.
  - On done_ready=1: done_valid=0 next cycle, go to IDLE.
  - done_ready may be held low indefinitely.
- Handshake rules:
  - start_ready=0 in RUN/DONE; start_valid there is ignored; no operands captured.
  - The minimum gap between consecutive accepts is WIDTH+2 cycles (one IDLE cycle after DONE).
- Input stability: a/b changes after the accept edge have no effect on the result.
- done_ready outside DONE has no effect.
- Reset mid-operation (RUN or DONE): abort immediately, reset state as above, the partial result is discarded.
- Arithmetic: the result is unsigned modulo 2^WIDTH; two's-complement interpretation is identical.
- No X on any output after reset.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, valid with done_valid.
  - ovf = signed overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]).
  - Operand sign bits are captured at accept.
  - ovf is registered on the RUN->DONE edge and held like diff.
- Undefined: ovf port and the captured sign bits do not exist; all other behaviour is identical.

Test Plan:
- Reset, then 10-3, WIDTH=8: accept 8'd10 - 8'd3 -> done_valid exactly 8 edges after accept; diff=8'd7, borrow=0, busy high for the duration.
- 3-10: 8'd3 - 8'd10 -> diff=8'hF9, borrow=1. Also 8'h00 - 8'h00 -> diff=0, borrow=0. Also 8'h00 - 8'hFF -> diff=8'h01, borrow=1.
- Backpressure: hold done_ready=0 for 5 cycles after done_valid while driving start_valid=1 with new operands -> done_valid, diff and borrow stay constant and start_ready stays 0. Raise done_ready -> IDLE next cycle, new operands accepted the following edge.
- Reset mid-RUN: assert rst_n=0 after 4 RUN cycles -> next cycle diff=0, borrow=0, done_valid=0, busy=0. start_ready=1 after release, and a fresh 8'd200 - 8'd100 yields diff=8'd100, borrow=0.
- Overflow, with SERIAL_SUB_OVF_EN defined:
  - 8'h80 - 8'h01 -> diff=8'h7F, borrow=0, ovf=1.
  - 8'h7F - 8'hFF -> diff=8'h80, borrow=1, ovf=1.
  - 8'd5 - 8'd3 -> ovf=0.
- Random regression: 1000 random a/b with random done_ready stalls, run at WIDTH=8 and WIDTH=16 -> every diff equals (a-b) mod 2^WIDTH and every borrow equals (a<b).

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             borrow_r;
  logic             done_valid_r;
  logic             busy_r;
  logic             start_ready_r;
  logic             d_s;
  logic             br_next_s;
  logic             last_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_sgn_r;
  logic             b_sgn_r;
  logic             ovf_r;
`endif

  function automatic logic sub_borrow(input logic ai, input logic bi, input logic br);
    return (~ai & bi) | (~(ai ^ bi) & br);
  endfunction

  // One full-subtractor bit slice on the current LSBs.
  always_comb begin
    d_s       = a_sh_r[0] ^ b_sh_r[0] ^ br_r;
    br_next_s = sub_borrow(a_sh_r[0], b_sh_r[0], br_r);
    last_s    = (cnt_r == LAST_CNT);
  end

  // Control FSM and serial datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      a_sh_r        <= {WIDTH{1'b0}};
      b_sh_r        <= {WIDTH{1'b0}};
      diff_r        <= {WIDTH{1'b0}};
      cnt_r         <= {CW{1'b0}};
      br_r          <= 1'b0;
      borrow_r      <= 1'b0;
      done_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      start_ready_r <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
      a_sgn_r       <= 1'b0;
      b_sgn_r       <= 1'b0;
      ovf_r         <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_valid) begin
            a_sh_r        <= a;
            b_sh_r        <= b;
            diff_r        <= {WIDTH{1'b0}};
            cnt_r         <= {CW{1'b0}};
            br_r          <= 1'b0;
            busy_r        <= 1'b1;
            start_ready_r <= 1'b0;
            state_r       <= ST_RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_sgn_r       <= a[WIDTH-1];
            b_sgn_r       <= b[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          diff_r <= {d_s, diff_r[WIDTH-1:1]};
          a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
          br_r   <= br_next_s;
          cnt_r  <= cnt_r + CNT_ONE;
          if (last_s) begin
            borrow_r     <= br_next_s;
            done_valid_r <= 1'b1;
            state_r      <= ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
            // d_s on the final slice is the result sign bit.
            ovf_r        <= (a_sgn_r != b_sgn_r) && (d_s != a_sgn_r);
`endif
          end
        end
        ST_DONE: begin
          if (done_ready) begin
            done_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
            start_ready_r <= 1'b1;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          done_valid_r  <= 1'b0;
          busy_r        <= 1'b0;
          start_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready = start_ready_r;
  assign diff        = diff_r;
  assign borrow      = borrow_r;
  assign done_valid  = done_valid_r;
  assign busy        = busy_r;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf         = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases on an 8-bit instance,
// random regression on 8- and 16-bit instances against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int W2 = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        done_ready = 1'b0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;

  logic          sr8, br8, dv8, busy8;
  logic [W-1:0]  diff8;
  logic          sr16, br16, dv16, busy16;
  logic [W2-1:0] diff16;
`ifdef SERIAL_SUB_OVF_EN
  logic          ovf8, ovf16;
`endif

  int tests_run = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(W)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr8),
    .a(a_in[W-1:0]), .b(b_in[W-1:0]), .diff(diff8), .borrow(br8),
    .done_valid(dv8), .done_ready(done_ready), .busy(busy8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(W2)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr16),
    .a(a_in[W2-1:0]), .b(b_in[W2-1:0]), .diff(diff16), .borrow(br16),
    .done_valid(dv16), .done_ready(done_ready), .busy(busy16)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf16)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_diff(input logic [31:0] x, input logic [31:0] y, input int w);
    longint unsigned m;
    m = (64'd1 << w) - 64'd1;
    return 32'((longint'(x) - longint'(y)) & m);
  endfunction

  function automatic logic model_borrow(input logic [31:0] x, input logic [31:0] y);
    return x < y;
  endfunction

  function automatic logic model_ovf(input logic [31:0] x, input logic [31:0] y, input int w);
    longint sx, sy, r, lim;
    lim = longint'(1) << (w - 1);
    sx = (longint'(x) >= lim) ? longint'(x) - 2 * lim : longint'(x);
    sy = (longint'(y) >= lim) ? longint'(y) - 2 * lim : longint'(y);
    r = sx - sy;
    return (r >= lim) || (r < -lim);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if ({dv8, busy8, br8, diff8} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL reset_state: got dv=%b busy=%b borrow=%b diff=%h, want all 0", dv8, busy8, br8, diff8);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (sr8 !== 1'b1) begin
      fails++;
      $display("FAIL reset_start_ready: got %b want 1", sr8);
    end
  endtask

  // Present operands at a negedge in IDLE; returns at the negedge right after the accept edge.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    a_in = x; b_in = y; start_valid = 1'b1;
    tests_run++;
    if (sr8 !== 1'b1) begin
      fails++;
      $display("FAIL start_ready_idle: got %b want 1", sr8);
    end
    @(negedge clk);
    start_valid = 1'b0;
    a_in = $urandom; b_in = $urandom;
  endtask

  task automatic wait_done(input logic [7:0] ed, input logic eb, input logic eo, input string name);
    int  edges;
    logic bad;
    edges = 0; bad = 1'b0;
    while (dv8 !== 1'b1 && edges < 40) begin
      if (busy8 !== 1'b1 || sr8 !== 1'b0) bad = 1'b1;
      @(negedge clk);
      edges++;
    end
    tests_run++;
    if (edges != W) begin
      fails++;
      $display("FAIL %s_latency: got %0d edges want %0d", name, edges, W);
    end
    tests_run++;
    if (bad || busy8 !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy: busy/start_ready wrong during RUN/DONE, busy=%b want 1", name, busy8);
    end
    tests_run++;
    if ({br8, diff8} !== {eb, ed}) begin
      fails++;
      $display("FAIL %s_result: got borrow=%b diff=%h want borrow=%b diff=%h", name, br8, diff8, eb, ed);
    end
`ifdef SERIAL_SUB_OVF_EN
    tests_run++;
    if (ovf8 !== eo) begin
      fails++;
      $display("FAIL %s_ovf: got %b want %b", name, ovf8, eo);
    end
`endif
  endtask

  task automatic release_result(input string name);
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    tests_run++;
    if ({dv8, sr8, busy8} !== 3'b010) begin
      fails++;
      $display("FAIL %s_release: got dv=%b sr=%b busy=%b want 0 1 0", name, dv8, sr8, busy8);
    end
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] ed,
                        input logic eb, input logic eo, input string name);
    start_op({24'd0, x}, {24'd0, y});
    wait_done(ed, eb, eo, name);
    release_result(name);
  endtask

  task automatic test_basic();
    run_op(8'd10, 8'd3, 8'd7, 1'b0, 1'b0, "sub_10_3");
    run_op(8'd3, 8'd10, 8'hF9, 1'b1, 1'b0, "sub_3_10");
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "sub_0_0");
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "sub_0_ff");
  endtask

  task automatic test_reset_mid_run();
    start_op(32'd77, 32'd12);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({dv8, busy8, br8, diff8} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL midrun_reset: got dv=%b busy=%b borrow=%b diff=%h want all 0", dv8, busy8, br8, diff8);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (sr8 !== 1'b1) begin
      fails++;
      $display("FAIL midrun_start_ready: got %b want 1", sr8);
    end
    run_op(8'd200, 8'd100, 8'd100, 1'b0, 1'b1, "sub_200_100");
  endtask

  task automatic test_backpressure();
    start_op(32'd100, 32'd25);
    wait_done(8'd75, 1'b0, 1'b0, "bp_first");
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1; a_in = $urandom; b_in = $urandom;
      @(negedge clk);
      tests_run++;
      if ({dv8, sr8, br8, diff8} !== {1'b1, 1'b0, 1'b0, 8'd75}) begin
        fails++;
        $display("FAIL bp_hold: got dv=%b sr=%b borrow=%b diff=%h want 1 0 0 4b", dv8, sr8, br8, diff8);
      end
    end
    a_in = 32'd50; b_in = 32'd20; done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    tests_run++;
    if ({dv8, sr8} !== 2'b01) begin
      fails++;
      $display("FAIL bp_idle: got dv=%b sr=%b want 0 1", dv8, sr8);
    end
    @(negedge clk);
    start_valid = 1'b0; a_in = $urandom; b_in = $urandom;
    tests_run++;
    if ({busy8, sr8} !== 2'b10) begin
      fails++;
      $display("FAIL bp_accept: got busy=%b sr=%b want 1 0", busy8, sr8);
    end
    wait_done(8'd30, 1'b0, 1'b0, "bp_second");
    release_result("bp_second");
  endtask

  task automatic test_ovf();
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "ovf_80_01");
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "ovf_7f_ff");
    run_op(8'd5, 8'd3, 8'd2, 1'b0, 1'b0, "ovf_5_3");
  endtask

  task automatic test_random();
    logic [31:0] q8a[$], q8b[$], q16a[$], q16b[$];
    logic [31:0] x, y;
    int done8, done16, cyc;
    done8 = 0; done16 = 0; cyc = 0;
    @(negedge clk);
    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    while ((done8 < 1000 || done16 < 1000) && cyc < 90000) begin
      start_valid = ($urandom_range(0, 3) != 0);
      done_ready  = ($urandom_range(0, 3) != 0);
      a_in = $urandom; b_in = $urandom;
      if (start_valid && sr8) begin q8a.push_back(a_in & 32'hFF); q8b.push_back(b_in & 32'hFF); end
      if (start_valid && sr16) begin q16a.push_back(a_in & 32'hFFFF); q16b.push_back(b_in & 32'hFFFF); end
      if (dv8 && done_ready) begin
        tests_run++;
        if (q8a.size() == 0) begin
          fails++;
          $display("FAIL rnd8_unexpected: got done_valid with no accepted operands, want none");
        end else begin
          x = q8a.pop_front(); y = q8b.pop_front();
          if ({br8, 24'd0, diff8} !== {model_borrow(x, y), model_diff(x, y, W)}) begin
            fails++;
            $display("FAIL rnd8 a=%h b=%h: got borrow=%b diff=%h want borrow=%b diff=%h",
                     x, y, br8, diff8, model_borrow(x, y), model_diff(x, y, W));
          end
`ifdef SERIAL_SUB_OVF_EN
          else if (ovf8 !== model_ovf(x, y, W)) begin
            fails++;
            $display("FAIL rnd8_ovf a=%h b=%h: got %b want %b", x, y, ovf8, model_ovf(x, y, W));
          end
`endif
        end
        done8++;
      end
      if (dv16 && done_ready) begin
        tests_run++;
        if (q16a.size() == 0) begin
          fails++;
          $display("FAIL rnd16_unexpected: got done_valid with no accepted operands, want none");
        end else begin
          x = q16a.pop_front(); y = q16b.pop_front();
          if ({br16, 16'd0, diff16} !== {model_borrow(x, y), model_diff(x, y, W2)}) begin
            fails++;
            $display("FAIL rnd16 a=%h b=%h: got borrow=%b diff=%h want borrow=%b diff=%h",
                     x, y, br16, diff16, model_borrow(x, y), model_diff(x, y, W2));
          end
`ifdef SERIAL_SUB_OVF_EN
          else if (ovf16 !== model_ovf(x, y, W2)) begin
            fails++;
            $display("FAIL rnd16_ovf a=%h b=%h: got %b want %b", x, y, ovf16, model_ovf(x, y, W2));
          end
`endif
        end
        done16++;
      end
      @(negedge clk);
      cyc++;
    end
    start_valid = 1'b0; done_ready = 1'b0;
    tests_run++;
    if (done8 < 1000 || done16 < 1000) begin
      fails++;
      $display("FAIL rnd_timeout: got %0d/%0d completions want 1000/1000", done8, done16);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_run();
    test_backpressure();
    test_ovf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
